// File: rtl/aes_pkg.sv
// aes_pkg: shared FSM state type, AES round count, xtime and FIPS-197 byte-index helpers
package aes_pkg;
  typedef enum logic [1:0] {IDLE, ADD0, ROUND, FINAL} aes_state_e;
  localparam int NR = 10;
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic int bidx(input int c, input int r);
    return 127 - 8 * (4 * c + r);
  endfunction
endpackage

// File: rtl/aes_round.sv
// aes_round: combinational AES round; state_in/round_key/is_final in, state_out = [MixColumns](ShiftRows(SubBytes)) ^ key
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  input  logic         is_final,
  output logic [127:0] state_out
);
  logic [127:0] sb, sr, mc;
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      aes_sbox u_sbox (.in_i(state_in[bidx(c, r) -: 8]), .out_o(sb[bidx(c, r) -: 8]));
      assign sr[bidx(c, r) -: 8] = sb[bidx((c + r) % 4, r) -: 8];
      assign mc[bidx(c, r) -: 8] = xtime(sr[bidx(c, r) -: 8]) ^ xtime(sr[bidx(c, (r + 1) % 4) -: 8])
                                 ^ sr[bidx(c, (r + 1) % 4) -: 8] ^ sr[bidx(c, (r + 2) % 4) -: 8]
                                 ^ sr[bidx(c, (r + 3) % 4) -: 8];
    end
  end
  assign state_out = (is_final ? sr : mc) ^ round_key;
endmodule

// File: rtl/aes_sbox.sv
// aes_sbox: AES forward S-box lookup; in_i byte in, out_o substituted byte out
module aes_sbox (
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);
  localparam logic [2047:0] TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  assign out_o = TABLE[11'd2047 - {in_i, 3'b000} -: 8];
endmodule

// File: rtl/aes_cipher_core.sv
// aes_cipher_core: iterative AES-128 encrypt; start/plain_text/cipher_key in, key_text/current_round to key_generator, round_key back, cipher_text/busy/done out
module aes_cipher_core #(
  parameter int NR = 10,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [127:0]  plain_text,
  input  logic [127:0]  cipher_key,
  output logic [127:0]  key_text,
  output logic [RW-1:0] current_round,
  input  logic [127:0]  round_key,
  output logic [127:0]  cipher_text,
  output logic          busy,
  output logic          done
);
  import aes_pkg::*;
  aes_state_e fsm_q, fsm_d;
  logic [127:0] state_q, state_d, key_q, key_d, ct_q, ct_d, round_out;
  logic [RW-1:0] rnd_q, rnd_d;
  logic done_q, done_d;
  aes_round u_round (
    .state_in (state_q),
    .round_key(round_key),
    .is_final (fsm_q == FINAL),
    .state_out(round_out)
  );
  always_comb begin
    fsm_d = fsm_q;
    state_d = state_q;
    key_d = key_q;
    ct_d = ct_q;
    rnd_d = rnd_q;
    done_d = 1'b0;
    case (fsm_q)
      IDLE: if (start) begin
        state_d = plain_text;
        key_d = cipher_key;
        rnd_d = '0;
        fsm_d = ADD0;
      end
      ADD0: begin
        state_d = state_q ^ round_key;
        rnd_d = RW'(1);
        fsm_d = ROUND;
      end
      ROUND: begin
        state_d = round_out;
        rnd_d = rnd_q + RW'(1);
        fsm_d = rnd_q == RW'(NR - 1) ? FINAL : ROUND;
      end
      FINAL: begin
        ct_d = round_out;
        done_d = 1'b1;
        rnd_d = '0;
        fsm_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= IDLE;
      state_q <= '0;
      key_q <= '0;
      ct_q <= '0;
      rnd_q <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      state_q <= state_d;
      key_q <= key_d;
      ct_q <= ct_d;
      rnd_q <= rnd_d;
      done_q <= done_d;
    end
  end
  assign key_text = key_q;
  assign current_round = rnd_q;
  assign cipher_text = ct_q;
  assign busy = fsm_q != IDLE;
  assign done = done_q;
endmodule
